// File: rtl/mem_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states and byte enables.
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam int         MEM_UNSIGNED = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_if.sv
// Data-memory req/ack port; the MEM stage is the master, the memory the slave.
interface mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed little-endian lane out of a read word and sign/zero-extends it.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addrLo,
    input  logic [2:0]        memOp,
    output logic [DATA_W-1:0] loadData
);

    logic signed [7:0]  byteLane;
    logic signed [15:0] halfLane;

    always_comb begin
        case (addrLo)
            2'd0:    byteLane = rdata[7:0];
            2'd1:    byteLane = rdata[15:8];
            2'd2:    byteLane = rdata[23:16];
            default: byteLane = rdata[31:24];
        endcase
        halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];

        case (memOp[1:0])
            MEM_B: loadData = memOp[MEM_UNSIGNED] ? {{(DATA_W-8){1'b0}}, byteLane}
                                                  : {{(DATA_W-8){byteLane[7]}}, byteLane};
            MEM_H: loadData = memOp[MEM_UNSIGNED] ? {{(DATA_W-16){1'b0}}, halfLane}
                                                  : {{(DATA_W-16){halfLane[15]}}, halfLane};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack port, MEM/WB register.
// Optional misaligned-access exception enabled by defining MEM_MISALIGN_EXC_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              RegWriteEn_i,
    input  logic [4:0]        RegWriteAddr_i,
    input  logic [DATA_W-1:0] AluRes_i,
    input  logic [DATA_W-1:0] StoreData_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        MemOp_i,
    output logic              stall_o,
    mem_if.master             dmem,
    output logic              wb_valid_o,
    output logic              RegWriteEn_o,
    output logic [4:0]        RegWriteAddr_o,
    output logic [DATA_W-1:0] RegWriteData_o,
    output logic              exc_o
);

    state_t            state;
    logic              destEn_p1;
    logic [2:0]        memOp_p1;
    logic [1:0]        addrLo_p1;
    logic              isLoad_p1;
    logic [DATA_W-1:0] loadData;
    logic              isMem;

    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            MEM_B:   byteEnable = BE_B0 << lo;
            MEM_H:   byteEnable = lo[1] ? BE_HHI : BE_HLO;
            default: byteEnable = BE_WORD;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] laneData(input logic [1:0] size, input logic [DATA_W-1:0] sd);
        case (size)
            MEM_B:   laneData = {4{sd[7:0]}};
            MEM_H:   laneData = {2{sd[15:0]}};
            default: laneData = sd;
        endcase
    endfunction

    assign isMem   = MemRead_i | MemWrite_i;
    assign stall_o = (state == ST_ACCESS);

`ifdef MEM_MISALIGN_EXC_EN
    logic misaligned;
    logic excReg;
    // Size encoding 11 counts as word, so bit 1 alone flags a word access.
    assign misaligned = ((MemOp_i[1:0] == MEM_H) && AluRes_i[0]) ||
                        (MemOp_i[1] && (AluRes_i[1:0] != 2'b00));
    assign exc_o = excReg;
`else
    assign exc_o = 1'b0;
`endif

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata    (dmem.mem_rdata),
        .addrLo   (addrLo_p1),
        .memOp    (memOp_p1),
        .loadData (loadData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            dmem.mem_req   <= 1'b0;
            dmem.mem_we    <= 1'b0;
            dmem.mem_addr  <= '0;
            dmem.mem_be    <= '0;
            dmem.mem_wdata <= '0;
            wb_valid_o     <= 1'b0;
            RegWriteEn_o   <= 1'b0;
            RegWriteAddr_o <= '0;
            RegWriteData_o <= '0;
            destEn_p1      <= 1'b0;
            memOp_p1       <= '0;
            addrLo_p1      <= '0;
            isLoad_p1      <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
            excReg         <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_EXC_EN
            excReg <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!valid_i) begin
                        wb_valid_o   <= 1'b0;
                        RegWriteEn_o <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
                    end else if (isMem && misaligned) begin
                        wb_valid_o   <= 1'b1;
                        RegWriteEn_o <= 1'b0;
                        excReg       <= 1'b1;
`endif
                    end else if (isMem) begin
                        // p0 -> p1: capture the access; a read+write combination is a load.
                        destEn_p1      <= RegWriteEn_i;
                        RegWriteAddr_o <= RegWriteAddr_i;
                        memOp_p1       <= MemOp_i;
                        addrLo_p1      <= AluRes_i[1:0];
                        isLoad_p1      <= MemRead_i;
                        dmem.mem_req   <= 1'b1;
                        dmem.mem_we    <= MemWrite_i & ~MemRead_i;
                        dmem.mem_addr  <= {AluRes_i[ADDR_W-1:2], 2'b00};
                        dmem.mem_be    <= MemRead_i ? BE_NONE : byteEnable(MemOp_i[1:0], AluRes_i[1:0]);
                        dmem.mem_wdata <= laneData(MemOp_i[1:0], StoreData_i);
                        wb_valid_o     <= 1'b0;
                        RegWriteEn_o   <= 1'b0;
                        state          <= ST_ACCESS;
                    end else begin
                        wb_valid_o     <= 1'b1;
                        RegWriteEn_o   <= RegWriteEn_i;
                        RegWriteAddr_o <= RegWriteAddr_i;
                        RegWriteData_o <= AluRes_i;
                    end
                end
                ST_ACCESS: begin
                    // p1 -> p2: completion writes the MEM/WB register.
                    if (dmem.mem_ack) begin
                        dmem.mem_req <= 1'b0;
                        dmem.mem_we  <= 1'b0;
                        wb_valid_o   <= 1'b1;
                        RegWriteEn_o <= isLoad_p1 & destEn_p1;
                        if (isLoad_p1) begin
                            RegWriteData_o <= loadData;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, reset abort, stall hold, misalignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        regWrEn;
    logic [4:0]  regWrAddr;
    logic [31:0] aluRes;
    logic [31:0] storeData;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memOp;
    logic        stall;
    logic        wbValid;
    logic        regWrEnOut;
    logic [4:0]  regWrAddrOut;
    logic [31:0] regWrData;
    logic        exc;

    int total = 0;
    int bad   = 0;

    mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid),
        .RegWriteEn_i   (regWrEn),
        .RegWriteAddr_i (regWrAddr),
        .AluRes_i       (aluRes),
        .StoreData_i    (storeData),
        .MemRead_i      (memRead),
        .MemWrite_i     (memWrite),
        .MemOp_i        (memOp),
        .stall_o        (stall),
        .dmem           (bus.master),
        .wb_valid_o     (wbValid),
        .RegWriteEn_o   (regWrEnOut),
        .RegWriteAddr_o (regWrAddrOut),
        .RegWriteData_o (regWrData),
        .exc_o          (exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] op, input logic [4:0] dst,
                           input logic [31:0] alu, input logic [31:0] sd, input logic en);
        valid     = 1'b1;
        memRead   = rd;
        memWrite  = wr;
        memOp     = op;
        regWrAddr = dst;
        aluRes    = alu;
        storeData = sd;
        regWrEn   = en;
    endtask

    task automatic idleInputs();
        valid    = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrEn  = 1'b0;
    endtask

    // Called in the first ACCESS cycle; holds off ack for 'waits' cycles, then acks with rdata.
    task automatic waitAck(input string tag, input int waits, input logic [31:0] rdata);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_stall_wait"}, stall, 1);
            chk({tag, "_req_held"}, bus.mem_req, 1);
            cycle();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        chk({tag, "_stall_ack"}, stall, 1);
        cycle();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_req_done"}, bus.mem_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idleInputs();
        memOp = 3'b000; regWrAddr = 5'd0; aluRes = 32'h0; storeData = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_wb_valid", wbValid, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_data", regWrData, 0);
        chk("rst_exc", exc, 0);
        rst = 1'b0;

        // ALU result passes straight through in one cycle
        present(0, 0, 3'b010, 5'd5, 32'h0000_1234, 32'h0, 1);
        chk("alu_stall_pre", stall, 0);
        cycle();
        idleInputs();
        chk("alu_wb_valid", wbValid, 1);
        chk("alu_data", regWrData, 32'h0000_1234);
        chk("alu_addr", regWrAddrOut, 5);
        chk("alu_en", regWrEnOut, 1);
        chk("alu_stall", stall, 0);
        cycle();
        chk("bubble_wb_valid", wbValid, 0);
        chk("bubble_en", regWrEnOut, 0);
        chk("bubble_data_hold", regWrData, 32'h0000_1234);

        // LB at 0x103, two wait cycles, top byte 0x80
        present(1, 0, 3'b000, 5'd7, 32'h0000_0103, 32'h0, 1);
        cycle();
        idleInputs();
        chk("lb_req", bus.mem_req, 1);
        chk("lb_we", bus.mem_we, 0);
        chk("lb_addr", bus.mem_addr, 32'h0000_0100);
        chk("lb_be", bus.mem_be, 4'b0000);
        chk("lb_wb_valid", wbValid, 0);
        waitAck("lb", 2, 32'h8012_3456);
        chk("lb_wb_valid_out", wbValid, 1);
        chk("lb_data", regWrData, 32'hFFFF_FF80);
        chk("lb_en", regWrEnOut, 1);
        chk("lb_rd", regWrAddrOut, 7);
        cycle();

        // LBU, same conditions
        present(1, 0, 3'b100, 5'd8, 32'h0000_0103, 32'h0, 1);
        cycle();
        idleInputs();
        waitAck("lbu", 2, 32'h8012_3456);
        chk("lbu_data", regWrData, 32'h0000_0080);
        cycle();

        // SH at 0x202
        present(0, 1, 3'b001, 5'd9, 32'h0000_0202, 32'hDEAD_BEEF, 1);
        cycle();
        idleInputs();
        chk("sh_we", bus.mem_we, 1);
        chk("sh_be", bus.mem_be, 4'b1100);
        chk("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", bus.mem_addr, 32'h0000_0200);
        waitAck("sh", 1, 32'h0);
        chk("sh_wb_valid", wbValid, 1);
        chk("sh_en", regWrEnOut, 0);
        chk("sh_we_done", bus.mem_we, 0);
        cycle();

        // SB at 0x301 and store with size encoding 11 (word)
        present(0, 1, 3'b000, 5'd1, 32'h0000_0301, 32'h1234_56A5, 0);
        cycle();
        idleInputs();
        chk("sb_be", bus.mem_be, 4'b0010);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        waitAck("sb", 1, 32'h0);
        cycle();
        present(0, 1, 3'b011, 5'd2, 32'h0000_0504, 32'hCAFE_F00D, 1);
        cycle();
        idleInputs();
        chk("sw11_be", bus.mem_be, 4'b1111);
        chk("sw11_wdata", bus.mem_wdata, 32'hCAFE_F00D);
        chk("sw11_addr", bus.mem_addr, 32'h0000_0504);
        waitAck("sw11", 1, 32'h0);
        cycle();

        // Reset during ACCESS, then a late ack
        present(1, 0, 3'b010, 5'd4, 32'h0000_0300, 32'h0, 1);
        cycle();
        idleInputs();
        chk("rstacc_req_pre", bus.mem_req, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstacc_req", bus.mem_req, 0);
        chk("rstacc_stall", stall, 0);
        chk("rstacc_wb_valid", wbValid, 0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        cycle();
        bus.mem_ack = 1'b0;
        chk("lateack_wb_valid", wbValid, 0);
        chk("lateack_req", bus.mem_req, 0);
        chk("lateack_en", regWrEnOut, 0);

        // LH at 0x402 with an ALU op held behind it while stalled
        present(1, 0, 3'b001, 5'd3, 32'h0000_0402, 32'h0, 1);
        cycle();
        present(0, 0, 3'b000, 5'd9, 32'h0000_ABCD, 32'h0, 1);
        chk("hold_wb_valid", wbValid, 0);
        waitAck("lh", 1, 32'h8001_1234);
        chk("lh_wb_valid", wbValid, 1);
        chk("lh_data", regWrData, 32'hFFFF_8001);
        chk("lh_rd", regWrAddrOut, 3);
        cycle();
        idleInputs();
        chk("held_wb_valid", wbValid, 1);
        chk("held_data", regWrData, 32'h0000_ABCD);
        chk("held_rd", regWrAddrOut, 9);
        cycle();
        chk("held_drain", wbValid, 0);

        // LW at 0x102
        present(1, 0, 3'b010, 5'd6, 32'h0000_0102, 32'h0, 1);
        cycle();
        idleInputs();
`ifdef MEM_MISALIGN_EXC_EN
        chk("mis_req", bus.mem_req, 0);
        chk("mis_stall", stall, 0);
        chk("mis_exc", exc, 1);
        chk("mis_wb_valid", wbValid, 1);
        chk("mis_en", regWrEnOut, 0);
        cycle();
        chk("mis_exc_pulse", exc, 0);
`else
        chk("lw_req", bus.mem_req, 1);
        chk("lw_addr", bus.mem_addr, 32'h0000_0100);
        chk("lw_exc", exc, 0);
        waitAck("lw", 1, 32'h5566_7788);
        chk("lw_data", regWrData, 32'h5566_7788);
        cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
